// File: rtl/if_prefetch_queue_pkg.sv
// Shared types and helpers for the prefetching instruction-fetch stage.
package if_prefetch_queue_pkg;

  localparam int PC_W           = 32;
  localparam int INST_W         = 32;
  localparam int IF_TO_ID_WIDTH = PC_W + INST_W;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_FLUSHD = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } if_to_id_t;

  // Next fetch address: predicted target on a hit, else sequential (wraps mod 2^32).
  function automatic logic [PC_W-1:0] next_fetch_pc(input logic [PC_W-1:0] pc,
                                                    input logic            taken,
                                                    input logic [PC_W-1:0] target);
    logic [PC_W-1:0] npc;
    if (taken) begin
      npc = target;
    end else begin
      npc = pc + PC_STEP;
    end
    return npc;
  endfunction

endpackage

// File: rtl/if_prefetch_queue_chk.sv
// Simulation-only invariants of the prefetch queue's credit scheme.
module if_prefetch_queue_chk #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 3
) (
  input logic             clk,
  input logic             rst,
  input logic [CNT_W-1:0] outstanding,
  input logic [CNT_W-1:0] q_count,
  input logic             q_push,
  input logic             q_pop,
  input logic             q_full
);

  a_outstanding: assert property (@(posedge clk) disable iff (!rst)
    outstanding <= CNT_W'(MAX_OUTSTANDING));

  a_credit: assert property (@(posedge clk) disable iff (!rst)
    ({1'b0, outstanding} + {1'b0, q_count}) <= (CNT_W+1)'(DEPTH));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(q_push && q_full && !q_pop));

endmodule

// File: rtl/if_prefetch_queue_fifo_sync.sv
// Small synchronous FIFO with clear; storage is reset so the head reads zero out of reset.
module if_prefetch_queue_fifo_sync #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer, count and storage update; clear empties the FIFO without touching storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_prefetch_queue.sv
// Pipelined instruction fetch: in-order requests in flight, fetched {pc,inst} queued for ID.
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      inst_req_valid,
  input  logic                      inst_req_ready,
  output logic [31:0]               PC,
  input  logic [31:0]               Instruction,
  input  logic                      Inst_Valid,
  output logic                      Inst_Ready,
  input  logic                      pred_taken,
  input  logic [31:0]               pred_target,
  input  logic                      flush,
  input  logic [31:0]               flush_pc,
  input  logic                      MemRead,
  output logic                      IF_to_ID_valid,
  input  logic                      ID_ready,
  output logic [IF_TO_ID_WIDTH-1:0] IF_to_ID_data
);

  localparam int CNT_W     = $clog2(DEPTH+1);
  localparam int TAG_CNT_W = $clog2(MAX_OUTSTANDING+1);
  localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);

  ctrl_state_t          state;
  ctrl_state_t          state_next;
  logic [CNT_W-1:0]     drop;
  logic [CNT_W-1:0]     drop_next;
  logic [CNT_W-1:0]     outstanding;
  logic [CNT_W-1:0]     q_count;
  logic [CNT_W:0]       credit;
  logic [TAG_CNT_W-1:0] tag_count;
  logic [31:0]          fetch_pc;
  logic [31:0]          tag_pc;
  logic                 run;
  logic                 tag_full;
  logic                 tag_empty;
  logic                 q_full;
  logic                 q_empty;
  logic                 req_fire;
  logic                 resp_fire;
  logic                 discard;
  logic                 q_push;
  logic                 id_fire;
  if_to_id_t            q_din;

  // The tag FIFO holds exactly one address per request in flight.
  assign outstanding = CNT_W'(tag_count);
  assign credit      = {1'b0, outstanding} + {1'b0, q_count};

  // Queue space is reserved at request time, so responses can always be accepted.
  assign inst_req_valid = run & ~flush & ~MemRead & ~tag_full &
                          (outstanding < MAX_OUT_C) & (credit < DEPTH_C);
  assign req_fire       = inst_req_valid & inst_req_ready;
  assign resp_fire      = Inst_Valid & ~tag_empty;
  assign discard        = flush | (state == ST_FLUSHD);
  assign q_push         = resp_fire & ~discard;
  assign q_din          = '{pc: tag_pc, inst: Instruction};

  assign PC             = fetch_pc;
  assign Inst_Ready     = run;
  assign IF_to_ID_valid = ~q_empty & ~flush;
  assign id_fire        = IF_to_ID_valid & ID_ready;

  if_prefetch_queue_fifo_sync #(.W(32), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .push  (req_fire),
    .din   (fetch_pc),
    .pop   (resp_fire),
    .dout  (tag_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  if_prefetch_queue_fifo_sync #(.W(IF_TO_ID_WIDTH), .DEPTH(DEPTH)) u_inst_queue (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (q_push),
    .din   (q_din),
    .pop   (id_fire),
    .dout  (IF_to_ID_data),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // Stale-response accounting and control state; a flush marks everything in flight stale.
  always_comb begin
    drop_next  = drop;
    state_next = state;
    if (flush) begin
      drop_next = outstanding - CNT_W'(resp_fire);
    end else if (resp_fire && (drop != '0)) begin
      drop_next = drop - 1'b1;
    end else begin
      drop_next = drop;
    end
    if (flush) begin
      state_next = (drop_next != '0) ? ST_FLUSHD : ST_RUN;
    end else begin
      case (state)
        ST_RUN:    state_next = ST_RUN;
        ST_FLUSHD: state_next = (drop_next == '0) ? ST_RUN : ST_FLUSHD;
        default:   state_next = ST_RUN;
      endcase
    end
  end

  // Control state, fetch address and the post-reset run flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      drop     <= '0;
      fetch_pc <= RESET_PC;
      run      <= 1'b0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
      run   <= 1'b1;
      if (flush) begin
        fetch_pc <= flush_pc;
      end else if (req_fire) begin
        fetch_pc <= next_fetch_pc(fetch_pc, pred_taken, pred_target);
      end else begin
        fetch_pc <= fetch_pc;
      end
    end
  end

  if_prefetch_queue_chk #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .outstanding (outstanding),
    .q_count     (q_count),
    .q_push      (q_push),
    .q_pop       (id_fire),
    .q_full      (q_full)
  );

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized bench: in-flight list and fetch queue modelled with SV queues, memory modelled in-order.
module tb_if_prefetch_queue;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic        clk;
  logic        rst;
  logic        inst_req_valid;
  logic        inst_req_ready;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        MemRead;
  logic        IF_to_ID_valid;
  logic        ID_ready;
  logic [63:0] IF_to_ID_data;

  if_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .inst_req_valid (inst_req_valid),
    .inst_req_ready (inst_req_ready),
    .PC             (PC),
    .Instruction    (Instruction),
    .Inst_Valid     (Inst_Valid),
    .Inst_Ready     (Inst_Ready),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .MemRead        (MemRead),
    .IF_to_ID_valid (IF_to_ID_valid),
    .ID_ready       (ID_ready),
    .IF_to_ID_data  (IF_to_ID_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } flight_t;

  flight_t     inflight[$];
  logic [63:0] idq[$];
  logic [31:0] mem_q[$];
  logic [31:0] m_pc;
  bit          m_run;

  int n_checks = 0;
  int n_pass   = 0;
  int idr_pct, rdy_pct, resp_pct, mr_pct, fl_pct, pr_pct;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic model_reset();
    inflight.delete();
    idq.delete();
    mem_q.delete();
    m_pc  = 32'h0000_0000;
    m_run = 1'b0;
  endtask

  task automatic zero_inputs();
    inst_req_ready = 1'b0;
    Instruction    = 32'h0;
    Inst_Valid     = 1'b0;
    pred_taken     = 1'b0;
    pred_target    = 32'h0;
    flush          = 1'b0;
    flush_pc       = 32'h0;
    MemRead        = 1'b0;
    ID_ready       = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_valid"}, 64'(inst_req_valid), 64'd0);
    check_eq({tag, "_id_valid"},  64'(IF_to_ID_valid), 64'd0);
    check_eq({tag, "_inst_ready"}, 64'(Inst_Ready),    64'd0);
    check_eq({tag, "_id_data"},   IF_to_ID_data,       64'd0);
    check_eq({tag, "_pc"},        64'(PC),             64'd0);
  endtask

  // One cycle: drive at the negedge, check settled outputs, advance the model over the posedge.
  task automatic step();
    logic [31:0] r;
    bit          exp_rv;
    bit          exp_iv;
    bit          resp;
    flight_t     e;
    ID_ready       = ($urandom_range(99) < idr_pct);
    inst_req_ready = ($urandom_range(99) < rdy_pct);
    MemRead        = ($urandom_range(99) < mr_pct);
    flush          = ($urandom_range(99) < fl_pct);
    r              = $urandom();
    flush_pc       = ($urandom_range(3) == 0) ? 32'hFFFF_FFFC : (r & 32'hFFFF_FFFC);
    pred_taken     = ($urandom_range(99) < pr_pct);
    r              = $urandom();
    pred_target    = r & 32'hFFFF_FFFC;
    if (mem_q.size() > 0) begin
      Inst_Valid  = ($urandom_range(99) < resp_pct);
      Instruction = inst_of(mem_q[0]);
    end else begin
      Inst_Valid  = ($urandom_range(9) == 0);
      Instruction = $urandom();
    end
    #1;
    exp_rv = m_run && !flush && !MemRead && (inflight.size() < MAX_OUT) &&
             (inflight.size() + idq.size() < DEPTH);
    exp_iv = (idq.size() > 0) && !flush;
    check_eq("pc",         64'(PC),             64'(m_pc));
    check_eq("req_valid",  64'(inst_req_valid), 64'(exp_rv));
    check_eq("id_valid",   64'(IF_to_ID_valid), 64'(exp_iv));
    check_eq("inst_ready", 64'(Inst_Ready),     64'(m_run));
    if (exp_iv) begin
      check_eq("id_data", IF_to_ID_data, idq[0]);
    end
    if (inst_req_valid && inst_req_ready) mem_q.push_back(PC);
    if (Inst_Valid && mem_q.size() > 0) void'(mem_q.pop_front());
    resp = Inst_Valid && (inflight.size() > 0);
    if (flush) begin
      if (resp) void'(inflight.pop_front());
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      idq.delete();
      m_pc = flush_pc;
    end else begin
      if (exp_iv && ID_ready) void'(idq.pop_front());
      if (resp) begin
        e = inflight.pop_front();
        if (!e.stale) idq.push_back({e.pc, Instruction});
      end
      if (exp_rv && inst_req_ready) begin
        inflight.push_back('{pc: m_pc, stale: 1'b0});
        m_pc = pred_taken ? pred_target : m_pc + 32'd4;
      end
    end
    m_run = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_knobs(input int idr, input int rdy, input int rsp,
                           input int mr, input int fl, input int pr);
    idr_pct  = idr;
    rdy_pct  = rdy;
    resp_pct = rsp;
    mr_pct   = mr;
    fl_pct   = fl;
    pr_pct   = pr;
  endtask

  initial begin
    rst = 1'b0;
    zero_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    // Streaming, 1-cycle memory, no stalls.
    set_knobs(100, 100, 100, 0, 0, 0);
    repeat (30) step();

    // ID stalled: the queue fills and requests stop.
    set_knobs(0, 100, 100, 0, 0, 0);
    repeat (12) step();
    #1;
    check_eq("stall_no_req",   64'(inst_req_valid), 64'd0);
    check_eq("stall_id_valid", 64'(IF_to_ID_valid), 64'd1);
    @(negedge clk);
    model_reset_keep();

    // Predicted branches.
    set_knobs(90, 100, 80, 0, 0, 30);
    repeat (60) step();

    // Frequent flushes with slow memory.
    set_knobs(70, 90, 50, 0, 12, 10);
    repeat (150) step();

    // Everything random.
    set_knobs(60, 70, 60, 20, 5, 20);
    repeat (400) step();

    // Reset in the middle of traffic.
    rst = 1'b0;
    zero_inputs();
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    check_reset_outputs("midrst_hold");
    model_reset();
    rst = 1'b1;

    set_knobs(75, 80, 70, 10, 4, 15);
    repeat (300) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // The explicit stall checks consume one clock with the stall inputs still applied; replay it in the model.
  task automatic model_reset_keep();
    bit resp;
    flight_t e;
    resp = Inst_Valid && (inflight.size() > 0);
    if (resp) begin
      e = inflight.pop_front();
      if (!e.stale) idq.push_back({e.pc, Instruction});
    end
    if (Inst_Valid && mem_q.size() > 0) void'(mem_q.pop_front());
  endtask

endmodule
